// File: rtl/instr_fetch_unit.sv
// Fetch stage for a 16x16 instruction RAM. It decodes each fetched word into fields and hands it to execute over a valid/ready handshake.
// Define PREFETCH_EN to read the next word while the current one is accepted, which gives 1 instruction/cycle.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned START_ADDR = 2,
    parameter int unsigned END_ADDR   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [2:0]        opcode,
    output logic [3:0]        funct,
    output logic [2:0]        rs1,
    output logic [2:0]        rs2,
    output logic [2:0]        rd,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_START = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] PC_END   = ADDR_W'(END_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_ir;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [DATA_W-1:0]   w_ir_nxt;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic                w_at_end;
    logic                w_word_nz;

    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_at_end  = (r_pc == PC_END);
    assign w_word_nz = (mem_data != '0);

    // State, program counter and instruction register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= PC_START;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    // Next-state, RAM request and register updates
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_mem_addr  = r_pc;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pc_nxt    = PC_START;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_rd_en     = 1'b1;
                w_ir_nxt    = mem_data;
                w_state_nxt = w_word_nz ? S_HOLD : S_DONE;
            end
            S_HOLD: begin
                if (instr_ready) begin
                    if (w_at_end) begin
                        w_state_nxt = S_DONE;
                    end else begin
`ifdef PREFETCH_EN
                        // Read the successor in the accept cycle so valid can stay high
                        w_mem_addr  = w_pc_inc;
                        w_rd_en     = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_ir_nxt    = mem_data;
                        w_state_nxt = w_word_nz ? S_HOLD : S_DONE;
`else
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_FETCH;
`endif
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    w_pc_nxt    = PC_START;
                    w_ir_nxt    = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status decodes follow the state register so that reset clears them immediately
    assign instr_valid = (r_state == S_HOLD);
    assign busy        = (r_state == S_FETCH) || (r_state == S_HOLD);
    assign halted      = (r_state == S_DONE);
    assign mem_addr    = w_mem_addr;
    assign mem_rd_en   = w_rd_en;
    assign pc_out      = r_pc;

    assign opcode = r_ir[15:13];
    assign funct  = r_ir[12:9];
    assign rs1    = r_ir[8:6];
    assign rs2    = r_ir[5:3];
    assign rd     = r_ir[2:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: it replays directed and random programs against a queue model of the fetch order.
// Build with PREFETCH_EN defined to check the prefetch timing instead.
module tb_instr_fetch_unit;

    localparam int START = 2;
    localparam int LAST  = 15;
`ifdef PREFETCH_EN
    localparam int GAP      = 1;
    localparam int GAP_HALT = 1;
`else
    localparam int GAP      = 2;
    localparam int GAP_HALT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  opcode;
    logic [3:0]  funct;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic [3:0]  pc_out;
    logic        busy;
    logic        halted;

    logic [15:0] ram [16];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_hs;

    always #5 clk = ~clk;

    assign mem_data = ram[mem_addr];

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_data    (mem_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .funct       (funct),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .pc_out      (pc_out),
        .busy        (busy),
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] obs_word();
        return {opcode, funct, rs1, rs2, rd};
    endfunction

    task automatic load_default();
        for (int a = 0; a < 16; a++) ram[4'(a)] = 16'h0000;
        ram[2] = 16'h0055;
        ram[3] = 16'h10F7;
    endtask

    // Pulse start; the cycle after the pulse must be a FETCH of START
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_busy",    32'(busy),        32'(1));
        chk("start_valid",   32'(instr_valid), 32'(0));
        chk("start_rd_en",   32'(mem_rd_en),   32'(1));
        chk("start_addr",    32'(mem_addr),    32'(START));
    endtask

    // mode 0: ready always high; 1: random ready and stray starts; 2: 5-cycle stall with a start in HOLD
    task automatic run_prog(input int mode, output int hs);
        int          q[$];
        int          cyc      = 0;
        int          last_hs  = -1;
        int          last_pc  = -1;
        int          exp_total;
        int          a;
        bit          stalled  = 1'b0;
        bit          seen_halt = 1'b0;
        logic [15:0] held_w   = '0;
        logic [3:0]  held_pc  = '0;
        logic [15:0] w;
        for (int i = START; i <= LAST; i++) begin
            if (ram[4'(i)] == 16'h0000) break;
            q.push_back(i);
        end
        exp_total = q.size();
        hs = 0;
        while (cyc < 200) begin
            @(negedge clk);
            case (mode)
                0:       instr_ready = 1'b1;
                1:       instr_ready = ($urandom % 3) != 0;
                default: instr_ready = (cyc >= 5);
            endcase
            start = (mode == 2 && cyc == 2) || (mode == 1 && ($urandom % 8) == 0);
            #1;
            if (cyc == 0) chk("first_valid_latency", 32'(instr_valid), 32'(q.size() != 0));
            if (mem_rd_en) chk("rd_addr_range", 32'(int'(mem_addr) >= START && int'(mem_addr) <= LAST), 32'(1));
            if (instr_valid) begin
                w = obs_word();
                if (stalled) begin
                    chk("hold_word", 32'(w), 32'(held_w));
                    chk("hold_pc",   32'(pc_out), 32'(held_pc));
                end
                if (instr_ready) begin
                    if (q.size() == 0) begin
                        chk("extra_handshake", 32'(hs + 1), 32'(exp_total));
                    end else begin
                        a = q.pop_front();
                        chk("hs_pc",   32'(pc_out), 32'(a));
                        chk("hs_word", 32'(w),      32'(ram[4'(a)]));
                    end
                    if (mode == 0 && last_hs >= 0) chk("hs_gap", 32'(cyc - last_hs), 32'(GAP));
`ifdef PREFETCH_EN
                    if (int'(pc_out) != LAST) begin
                        chk("pf_rd_en", 32'(mem_rd_en), 32'(1));
                        chk("pf_addr",  32'(mem_addr),  32'(int'(pc_out) + 1));
                    end else begin
                        chk("pf_end_rd_en", 32'(mem_rd_en), 32'(0));
                    end
`else
                    chk("hold_rd_en", 32'(mem_rd_en), 32'(0));
`endif
                    last_hs = cyc;
                    last_pc = int'(pc_out);
                    hs++;
                    stalled = 1'b0;
                end else begin
                    chk("stall_rd_en", 32'(mem_rd_en), 32'(0));
                    stalled = 1'b1;
                    held_w  = w;
                    held_pc = pc_out;
                end
            end
            if (halted) begin
                seen_halt = 1'b1;
                if (mode == 0 && last_hs >= 0)
                    chk("halt_gap", 32'(cyc - last_hs), 32'((last_pc == LAST) ? 1 : GAP_HALT));
                break;
            end
            cyc++;
        end
        start = 1'b0;
        chk("reached_halt", 32'(seen_halt), 32'(1));
        chk("hs_count",     32'(hs),        32'(exp_total));
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        instr_ready = 1'b0;
        load_default();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid",  32'(instr_valid), 32'(0));
        chk("rst_busy",   32'(busy),        32'(0));
        chk("rst_halted", 32'(halted),      32'(0));
        chk("rst_rd_en",  32'(mem_rd_en),   32'(0));
        chk("rst_pc",     32'(pc_out),      32'(START));
        chk("rst_word",   32'(obs_word()),  32'(0));
        rst = 1'b0;

        // Basic two-instruction program, ready held high
        do_start();
        run_prog(0, n_hs);
        chk("t2_hs_count", 32'(n_hs), 32'(2));

        // Reset while an instruction is held
        do_start();
        @(negedge clk);
        instr_ready = 1'b0;
        #1;
        chk("t1_in_hold", 32'(instr_valid), 32'(1));
        rst = 1'b1;
        #1;
        chk("t1_async_valid", 32'(instr_valid), 32'(0));
        chk("t1_async_busy",  32'(busy),        32'(0));
        chk("t1_async_rd_en", 32'(mem_rd_en),   32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t1_pc",     32'(pc_out),     32'(START));
        chk("t1_word",   32'(obs_word()), 32'(0));
        chk("t1_halted", 32'(halted),     32'(0));

        // Backpressure with an ignored start in HOLD
        do_start();
        run_prog(2, n_hs);

        // Every address holds an instruction: stop at the last address without wrapping
        for (int i = START; i <= LAST; i++) ram[4'(i)] = 16'h0001;
        do_start();
        run_prog(0, n_hs);
        chk("t4_hs_count", 32'(n_hs), 32'(14));

        // Restart from DONE
        load_default();
        do_start();
        run_prog(0, n_hs);
        chk("t5_hs_count", 32'(n_hs), 32'(2));

        // Random programs with random backpressure
        for (int t = 0; t < 10; t++) begin
            int len;
            len = $urandom_range(0, 14);
            for (int i = 0; i < 16; i++) ram[4'(i)] = 16'($urandom_range(1, 65535));
            if (START + len <= LAST) ram[4'(START + len)] = 16'h0000;
            do_start();
            run_prog((t % 3 == 0) ? 0 : 1, n_hs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
